pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Produces the per-stage capture enables and bubble-flush controls consumed by the four pipeline registers (FeDe, DeEx, ExMe, MeWb) and the PC register.
- Covers load-use and flag-use hazards, control-flow redirects from Execute, and instruction- and data-memory wait states.
- Sits beside the pipeline registers as the single source of every stall and flush in the core.

Parameters:
- REDIRECT_EXTRA, 1, extra cycles after a redirect during which FeDe is flushed to kill wrong-path fetches still in flight (0..7).
- CNT_W, 16, width of the saturating stall and flush performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  async active-low reset
- de_reg_1_sel  in  5  Decode source register 1
- de_reg_2_sel  in  5  Decode source register 2
- de_reg_1_used  in  1  Decode reads source 1
- de_reg_2_used  in  1  Decode reads source 2
- de_FL_read  in  1  Decode reads flags
- ex_load  in  1  Execute holds a load (mem_en & ~mem_wrt, result from memory)
- ex_reg_wrt_en  in  1  Execute writes a GPR
- ex_reg_wrt_sel  in  5  Execute destination register
- ex_FL_write  in  1  Execute writes flags
- ex_redirect  in  1  taken branch or jump resolved in Execute (1-cycle pulse)
- imem_busy  in  1  instruction fetch not ready
- dmem_busy  in  1  data access in Memory stage not complete
- pc_en  out  1  PC update enable
- FeDe_en, DeEx_en, ExMe_en, MeWb_en  out  1 each  capture enables (1 = load d)
- FeDe_flush, DeEx_flush, ExMe_flush, MeWb_flush  out  1 each  load bubble (all zero) at next edge
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
- flush_cnt  out  CNT_W  cycles with any flush=1, saturating

Behaviour:
- Reset behaviour:
  - On reset, all outputs are 0 and the state is RUN.
  - pending_redirect and redir_cnt clear to 0.
  - Reset mid-operation abandons any MEM_WAIT, REDIRECT or pending state immediately.
- Flush rule: wherever a flush is 1, the matching en is also 1.
- Hazard detection (combinational, r0 excluded):
  - gpr_hz = ex_load & ex_reg_wrt_en & ex_reg_wrt_sel!=0 & ((de_reg_1_used & de_reg_1_sel==ex_reg_wrt_sel) | (de_reg_2_used & de_reg_2_sel==ex_reg_wrt_sel)).
  - fl_hz = ex_FL_write & de_FL_read.
  - use_hz = gpr_hz | fl_hz.
- Outputs are combinational from state and inputs. Priority, highest first:
  1. dmem_busy: freeze. pc_en and every en are 0; every flush is 0.
  2. ex_redirect (or pending_redirect on leaving MEM_WAIT): pc_en=1, all en=1, FeDe_flush=1, DeEx_flush=1.
  3. REDIRECT state with redir_cnt>0: normal advance with FeDe_flush=1.
  4. use_hz: pc_en=0, FeDe_en=0, DeEx_flush=1, ExMe_en=1, MeWb_en=1. Exactly one bubble; no state is needed because the bubble clears the hazard.
  5. imem_busy: pc_en=0, FeDe_flush=1, DeEx_en=ExMe_en=MeWb_en=1.
  6. otherwise: pc_en=1 and all en=1.
- FSM (hazard_pkg::hz_state_t):
  - RUN:
    - dmem_busy -> MEM_WAIT.
    - ex_redirect & REDIRECT_EXTRA>0 -> REDIRECT with redir_cnt=REDIRECT_EXTRA.
  - MEM_WAIT:
    - Stays while dmem_busy.
    - ex_redirect asserted during MEM_WAIT sets pending_redirect; it is never lost.
    - On dmem_busy=0, pending_redirect is applied in that cycle, then cleared.
    - Exit to REDIRECT (if REDIRECT_EXTRA>0 and a redirect was applied), else to RUN.
  - REDIRECT:
    - redir_cnt decrements on each non-frozen cycle; -> RUN when it reaches 0 after the decrement.
    - A new ex_redirect reloads redir_cnt to REDIRECT_EXTRA.
    - dmem_busy -> MEM_WAIT; redir_cnt is held and the state resumes to REDIRECT afterwards.
- Simultaneous events: ex_redirect with use_hz resolves to the redirect, because the Decode instruction is wrong-path. imem_busy during REDIRECT flushes FeDe either way.
- Counters: each increments by 1 per qualifying cycle and saturates at all-ones. Freeze cycles count toward stall_cnt.

Decomposition:
- hazard_pkg:
  - hz_state_t enum {RUN, MEM_WAIT, REDIRECT}
  - REG_ZERO = 5'd0
  - pipe_ctrl_t struct bundling en/flush per stage
- Sub-module hazard_detect: the combinational gpr_hz/fl_hz compare, reused later by the forwarding unit.

Test Plan:
- Load-use: ex_load=1, ex_reg_wrt_sel=5, de_reg_2_sel=5, de_reg_2_used=1 -> one cycle of pc_en=0, FeDe_en=0, DeEx_flush=1; normal advance the next cycle; stall_cnt=1.
- r0 exclusion: same stimulus with sel=0 -> no stall. Flag case: ex_FL_write=1, de_FL_read=1 -> one bubble.
- Redirect, REDIRECT_EXTRA=1: ex_redirect pulse -> FeDe_flush=DeEx_flush=1 that cycle; FeDe_flush=1 only on the next cycle; RUN after that.
- Memory wait: dmem_busy high for 3 cycles with ex_redirect pulsed in cycle 2 -> all en=0 for 3 cycles; redirect flush is applied in the first cycle after dmem_busy falls.
- Priority: ex_redirect, use_hz and imem_busy together -> redirect response only; dmem_busy added -> pure freeze.
- Reset mid-REDIRECT and counter saturation with CNT_W=4: async rst_n low -> all outputs 0 immediately. 20 stall cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the r0 encoding
// and the per-stage enable/flush bundle handed to the pipeline registers.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bit positions of each pipeline register inside pipe_ctrl_t.en / .flush
  localparam int FEDE = 3;
  localparam int DEEX = 2;
  localparam int EXME = 1;
  localparam int MEWB = 0;

  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] flush;
  } pipe_ctrl_t;

  function automatic pipe_ctrl_t ctrl_advance();
    pipe_ctrl_t c;
    c.pc_en = 1'b1;
    c.en    = 4'hF;
    c.flush = 4'h0;
    return c;
  endfunction

  function automatic pipe_ctrl_t ctrl_freeze();
    pipe_ctrl_t c;
    c.pc_en = 1'b0;
    c.en    = 4'h0;
    c.flush = 4'h0;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use and flag-use hazard compare between Decode sources and the Execute
// producer; r0 never creates a dependency.
module hazard_detect (
  input  logic [4:0] de_reg_1_sel,
  input  logic [4:0] de_reg_2_sel,
  input  logic       de_reg_1_used,
  input  logic       de_reg_2_used,
  input  logic       de_FL_read,
  input  logic       ex_load,
  input  logic       ex_reg_wrt_en,
  input  logic [4:0] ex_reg_wrt_sel,
  input  logic       ex_FL_write,
  output logic       gpr_hz,
  output logic       fl_hz
);
  import hazard_pkg::*;

  logic src_1_match;
  logic src_2_match;

  assign src_1_match = de_reg_1_used && (de_reg_1_sel == ex_reg_wrt_sel);
  assign src_2_match = de_reg_2_used && (de_reg_2_sel == ex_reg_wrt_sel);

  assign gpr_hz = ex_load && ex_reg_wrt_en && (ex_reg_wrt_sel != REG_ZERO)
                  && (src_1_match || src_2_match);
  assign fl_hz  = ex_FL_write && de_FL_read;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: derives PC and pipeline-register enables and
// bubble flushes from hazards, redirects and memory wait states.
module pipe_hazard_ctrl #(
  parameter int REDIRECT_EXTRA = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       de_reg_1_sel,
  input  logic [4:0]       de_reg_2_sel,
  input  logic             de_reg_1_used,
  input  logic             de_reg_2_used,
  input  logic             de_FL_read,
  input  logic             ex_load,
  input  logic             ex_reg_wrt_en,
  input  logic [4:0]       ex_reg_wrt_sel,
  input  logic             ex_FL_write,
  input  logic             ex_redirect,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             FeDe_en,
  output logic             DeEx_en,
  output logic             ExMe_en,
  output logic             MeWb_en,
  output logic             FeDe_flush,
  output logic             DeEx_flush,
  output logic             ExMe_flush,
  output logic             MeWb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import hazard_pkg::*;

  localparam logic [2:0] REDIR_LOAD = 3'(REDIRECT_EXTRA);

  hz_state_t        state_q, state_d;
  logic [2:0]       redir_cnt_q, redir_cnt_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             gpr_hz, fl_hz, use_hz;
  pipe_ctrl_t       ctrl_c, ctrl_o;

  hazard_detect u_detect (
    .de_reg_1_sel   (de_reg_1_sel),
    .de_reg_2_sel   (de_reg_2_sel),
    .de_reg_1_used  (de_reg_1_used),
    .de_reg_2_used  (de_reg_2_used),
    .de_FL_read     (de_FL_read),
    .ex_load        (ex_load),
    .ex_reg_wrt_en  (ex_reg_wrt_en),
    .ex_reg_wrt_sel (ex_reg_wrt_sel),
    .ex_FL_write    (ex_FL_write),
    .gpr_hz         (gpr_hz),
    .fl_hz          (fl_hz)
  );

  assign use_hz = gpr_hz | fl_hz;

  // The cycle that leaves MEM_WAIT stands in for the frozen REDIRECT cycle, so
  // a held redir_cnt keeps flushing FeDe and counting down from there.
  always_comb begin
    ctrl_c      = ctrl_advance();
    state_d     = state_q;
    redir_cnt_d = redir_cnt_q;
    pending_d   = pending_q;

    if (dmem_busy) begin
      ctrl_c    = ctrl_freeze();
      state_d   = MEM_WAIT;
      pending_d = pending_q | ex_redirect;
    end else if (ex_redirect || pending_q) begin
      ctrl_c.flush[FEDE] = 1'b1;
      ctrl_c.flush[DEEX] = 1'b1;
      pending_d          = 1'b0;
      redir_cnt_d        = REDIR_LOAD;
      state_d            = (REDIR_LOAD != 3'd0) ? REDIRECT : RUN;
    end else if ((state_q != RUN) && (redir_cnt_q != 3'd0)) begin
      ctrl_c.flush[FEDE] = 1'b1;
      redir_cnt_d        = redir_cnt_q - 3'd1;
      state_d            = (redir_cnt_q != 3'd1) ? REDIRECT : RUN;
    end else begin
      state_d = RUN;
      if (use_hz) begin
        ctrl_c.pc_en       = 1'b0;
        ctrl_c.en[FEDE]    = 1'b0;
        ctrl_c.flush[DEEX] = 1'b1;
      end else if (imem_busy) begin
        ctrl_c.pc_en       = 1'b0;
        ctrl_c.flush[FEDE] = 1'b1;
      end
    end
  end

  assign ctrl_o = rst_n ? ctrl_c : ctrl_freeze();

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctrl_c.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((ctrl_c.flush != 4'h0) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      redir_cnt_q <= 3'd0;
      pending_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      redir_cnt_q <= redir_cnt_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_en      = ctrl_o.pc_en;
  assign FeDe_en    = ctrl_o.en[FEDE];
  assign DeEx_en    = ctrl_o.en[DEEX];
  assign ExMe_en    = ctrl_o.en[EXME];
  assign MeWb_en    = ctrl_o.en[MEWB];
  assign FeDe_flush = ctrl_o.flush[FEDE];
  assign DeEx_flush = ctrl_o.flush[DEEX];
  assign ExMe_flush = ctrl_o.flush[EXME];
  assign MeWb_flush = ctrl_o.flush[MEWB];
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int EXTRA = 1;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    de_reg_1_sel = '0, de_reg_2_sel = '0, ex_reg_wrt_sel = '0;
  logic          de_reg_1_used = 0, de_reg_2_used = 0, de_FL_read = 0;
  logic          ex_load = 0, ex_reg_wrt_en = 0, ex_FL_write = 0, ex_redirect = 0;
  logic          imem_busy = 0, dmem_busy = 0;
  logic          pc_en, FeDe_en, DeEx_en, ExMe_en, MeWb_en;
  logic          FeDe_flush, DeEx_flush, ExMe_flush, MeWb_flush;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [8:0]    act_ctrl;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0] r1;
    logic [4:0] r2;
    logic       u1, u2, flr, ld, wen;
    logic [4:0] wsel;
    logic       flw, redir, ib, db;
  } stim_t;

  // model: remaining wrong-path flush cycles, redirect held across a freeze, counters
  int         m_left, n_left;
  bit         m_pending, n_pending;
  int         m_stall, m_flush;
  logic       e_pc;
  logic [3:0] e_en, e_fl;
  logic [8:0] exp_ctrl;
  int         exp_stall, exp_flush;

  pipe_hazard_ctrl #(.REDIRECT_EXTRA(EXTRA), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .de_reg_1_sel(de_reg_1_sel), .de_reg_2_sel(de_reg_2_sel),
    .de_reg_1_used(de_reg_1_used), .de_reg_2_used(de_reg_2_used),
    .de_FL_read(de_FL_read), .ex_load(ex_load), .ex_reg_wrt_en(ex_reg_wrt_en),
    .ex_reg_wrt_sel(ex_reg_wrt_sel), .ex_FL_write(ex_FL_write),
    .ex_redirect(ex_redirect), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .FeDe_en(FeDe_en), .DeEx_en(DeEx_en), .ExMe_en(ExMe_en),
    .MeWb_en(MeWb_en), .FeDe_flush(FeDe_flush), .DeEx_flush(DeEx_flush),
    .ExMe_flush(ExMe_flush), .MeWb_flush(MeWb_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign act_ctrl = {pc_en, FeDe_en, DeEx_en, ExMe_en, MeWb_en,
                     FeDe_flush, DeEx_flush, ExMe_flush, MeWb_flush};

  always #5 clk = ~clk;

  task automatic model_reset();
    m_left = 0; m_pending = 0; m_stall = 0; m_flush = 0;
  endtask

  // Drive one cycle of inputs (called just after a falling edge) and predict outputs
  task automatic apply_stimulus(input stim_t s);
    bit gpr, use_hz;
    de_reg_1_sel = s.r1;  de_reg_2_sel = s.r2;
    de_reg_1_used = s.u1; de_reg_2_used = s.u2; de_FL_read = s.flr;
    ex_load = s.ld; ex_reg_wrt_en = s.wen; ex_reg_wrt_sel = s.wsel;
    ex_FL_write = s.flw; ex_redirect = s.redir; imem_busy = s.ib; dmem_busy = s.db;
    gpr = s.ld && s.wen && (s.wsel != 0) &&
          ((s.u1 && s.r1 == s.wsel) || (s.u2 && s.r2 == s.wsel));
    use_hz = gpr || (s.flw && s.flr);
    n_left = m_left; n_pending = m_pending;
    if (s.db) begin
      e_pc = 0; e_en = 4'b0000; e_fl = 4'b0000;
      n_pending = m_pending || s.redir;
    end else if (s.redir || m_pending) begin
      e_pc = 1; e_en = 4'b1111; e_fl = 4'b1100;
      n_pending = 0; n_left = EXTRA;
    end else if (m_left > 0) begin
      e_pc = 1; e_en = 4'b1111; e_fl = 4'b1000;
      n_left = m_left - 1;
    end else if (use_hz) begin
      e_pc = 0; e_en = 4'b0111; e_fl = 4'b0100;
    end else if (s.ib) begin
      e_pc = 0; e_en = 4'b1111; e_fl = 4'b1000;
    end else begin
      e_pc = 1; e_en = 4'b1111; e_fl = 4'b0000;
    end
    exp_ctrl  = {e_pc, e_en, e_fl};
    exp_stall = m_stall;
    exp_flush = m_flush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_left = n_left; m_pending = n_pending;
    if (!e_pc && m_stall < CMAX) m_stall++;
    if (e_fl != 0 && m_flush < CMAX) m_flush++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic test_reset();
    stim_t s;
    s = '1;
    apply_stimulus(s);
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (act_ctrl !== 9'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b want %b", act_ctrl, 9'b0);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || act_ctrl !== 9'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: ctrl=%b stall=%0d flush=%0d want all 0", act_ctrl, stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_load_use();
    stim_t s;
    do_reset();
    s = idle(); s.ld = 1; s.wen = 1; s.wsel = 5; s.r2 = 5; s.u2 = 1;
    apply_stimulus(s);
    checks++;
    if (act_ctrl !== 9'b0_0111_0100 || act_ctrl !== exp_ctrl) begin
      errors++; $display("[TB] FAIL load_use_bubble: got %b want %b", act_ctrl, 9'b0_0111_0100);
    end
    tick();
    apply_stimulus(idle());
    checks++;
    if (act_ctrl !== 9'b1_1111_0000) begin
      errors++; $display("[TB] FAIL load_use_resume: got %b want %b", act_ctrl, 9'b1_1111_0000);
    end
    checks++;
    if (stall_cnt !== 1 || flush_cnt !== 1) begin
      errors++; $display("[TB] FAIL load_use_counters: stall=%0d flush=%0d want 1 1", stall_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_r0_and_flags();
    stim_t s;
    do_reset();
    s = idle(); s.ld = 1; s.wen = 1; s.wsel = 0; s.r2 = 0; s.u2 = 1; s.r1 = 0; s.u1 = 1;
    apply_stimulus(s);
    checks++;
    if (act_ctrl !== 9'b1_1111_0000) begin
      errors++; $display("[TB] FAIL r0_no_stall: got %b want %b", act_ctrl, 9'b1_1111_0000);
    end
    tick();
    s = idle(); s.flw = 1; s.flr = 1;
    apply_stimulus(s);
    checks++;
    if (act_ctrl !== 9'b0_0111_0100) begin
      errors++; $display("[TB] FAIL flag_bubble: got %b want %b", act_ctrl, 9'b0_0111_0100);
    end
    tick();
    s = idle(); s.ld = 1; s.wen = 1; s.wsel = 9; s.r1 = 9; s.u1 = 0; s.r2 = 3; s.u2 = 1;
    apply_stimulus(s);
    checks++;
    if (act_ctrl !== 9'b1_1111_0000) begin
      errors++; $display("[TB] FAIL unused_src_no_stall: got %b want %b", act_ctrl, 9'b1_1111_0000);
    end
    tick();
  endtask

  task automatic test_redirect();
    stim_t s;
    logic [8:0] want [3];
    want[0] = 9'b1_1111_1100; want[1] = 9'b1_1111_1000; want[2] = 9'b1_1111_0000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.redir = (i == 0);
      apply_stimulus(s);
      checks++;
      if (act_ctrl !== want[i] || act_ctrl !== exp_ctrl) begin
        errors++; $display("[TB] FAIL redirect_cycle%0d: got %b want %b", i, act_ctrl, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    stim_t s;
    logic [8:0] want [6];
    want[0] = 9'b0; want[1] = 9'b0; want[2] = 9'b0;
    want[3] = 9'b1_1111_1100; want[4] = 9'b1_1111_1000; want[5] = 9'b1_1111_0000;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      s = idle(); s.db = (i < 3); s.redir = (i == 1);
      apply_stimulus(s);
      checks++;
      if (act_ctrl !== want[i] || act_ctrl !== exp_ctrl) begin
        errors++; $display("[TB] FAIL mem_wait_cycle%0d: got %b want %b", i, act_ctrl, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    stim_t s;
    do_reset();
    s = idle(); s.redir = 1; s.ib = 1; s.ld = 1; s.wen = 1; s.wsel = 7; s.r1 = 7; s.u1 = 1;
    s.db = 1;
    apply_stimulus(s);
    checks++;
    if (act_ctrl !== 9'b0) begin
      errors++; $display("[TB] FAIL prio_freeze: got %b want %b", act_ctrl, 9'b0);
    end
    tick();
    s.db = 0;
    apply_stimulus(s);
    checks++;
    if (act_ctrl !== 9'b1_1111_1100) begin
      errors++; $display("[TB] FAIL prio_redirect: got %b want %b", act_ctrl, 9'b1_1111_1100);
    end
    tick();
    s = idle(); s.ib = 1;
    apply_stimulus(s);
    checks++;
    if (act_ctrl !== 9'b1_1111_1000 || act_ctrl !== exp_ctrl) begin
      errors++; $display("[TB] FAIL prio_imem_in_redirect: got %b want %b", act_ctrl, 9'b1_1111_1000);
    end
    tick();
  endtask

  task automatic test_reset_mid_redirect();
    stim_t s;
    do_reset();
    s = idle(); s.redir = 1;
    apply_stimulus(s);
    tick();
    apply_stimulus(idle());
    #1;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (act_ctrl !== 9'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL async_reset: ctrl=%b flush=%0d want 0 0", act_ctrl, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    apply_stimulus(idle());
    checks++;
    if (act_ctrl !== 9'b1_1111_0000) begin
      errors++; $display("[TB] FAIL reset_abandons_redirect: got %b want %b", act_ctrl, 9'b1_1111_0000);
    end
    tick();
  endtask

  task automatic test_saturation();
    stim_t s;
    do_reset();
    s = idle(); s.ib = 1;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(s);
      checks++;
      if (act_ctrl !== 9'b0_1111_1000 || stall_cnt !== CW'(exp_stall)) begin
        errors++;
        $display("[TB] FAIL sat_cycle%0d: ctrl=%b stall=%0d want %b %0d", i, act_ctrl, stall_cnt, 9'b0_1111_1000, exp_stall);
      end
      tick();
    end
    apply_stimulus(idle());
    checks++;
    if (stall_cnt !== 4'd15 || flush_cnt !== 4'd15) begin
      errors++; $display("[TB] FAIL saturation: stall=%0d flush=%0d want 15 15", stall_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    stim_t s;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s.r1 = 5'($urandom_range(0, 7));  s.r2 = 5'($urandom_range(0, 7));
      s.wsel = 5'($urandom_range(0, 7));
      s.u1 = $urandom_range(0, 1) == 1;  s.u2 = $urandom_range(0, 1) == 1;
      s.ld = $urandom_range(0, 1) == 1;  s.wen = $urandom_range(0, 3) != 0;
      s.flr = $urandom_range(0, 2) == 0; s.flw = $urandom_range(0, 2) == 0;
      s.redir = $urandom_range(0, 7) == 0;
      s.ib = $urandom_range(0, 3) == 0;
      s.db = $urandom_range(0, 5) == 0;
      apply_stimulus(s);
      checks++;
      if (act_ctrl !== exp_ctrl) begin
        errors++; $display("[TB] FAIL random_ctrl[%0d]: got %b want %b", i, act_ctrl, exp_ctrl);
      end
      checks++;
      if (stall_cnt !== CW'(exp_stall) || flush_cnt !== CW'(exp_flush)) begin
        errors++;
        $display("[TB] FAIL random_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_r0_and_flags();
    test_redirect();
    test_mem_wait();
    test_priority();
    test_reset_mid_redirect();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
